// File: rtl/store_checker.sv
// Store-bus monitor for the single-cycle MIPS core: once armed with an expected
// address/data pair it logs every store and resolves to PASS, FAIL or TIMEOUT.
module store_checker #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            memwrite,
  input  logic [31:0]     dataadr,
  input  logic [31:0]     writedata,
  input  logic            arm,
  input  logic [31:0]     exp_adr,
  input  logic [31:0]     exp_data,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic            timeout,
  output logic [CNTW-1:0] store_count,
  output logic            log_valid,
  input  logic            log_ready,
  output logic [31:0]     log_adr,
  output logic [31:0]     log_data,
  output logic            log_overflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_PASS  = 3'd2;
  localparam logic [2:0] S_FAIL  = 3'd3;
  localparam logic [2:0] S_TOUT  = 3'd4;

  localparam logic [CNTW-1:0] CYC_LAST = CNTW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [AW:0]     PTR_ONE  = (AW+1)'(1);

  logic [2:0]      state, state_nx;
  logic [31:0]     exp_adr_q, exp_data_q;
  logic [CNTW-1:0] cyc_cnt;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [31:0]     mem_adr  [DEPTH];
  logic [31:0]     mem_data [DEPTH];

  logic armed, push_req, push, pop, empty, full, adr_hit, data_hit;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign armed    = (state == S_ARMED);
  assign adr_hit  = (dataadr == exp_adr_q);
  assign data_hit = (writedata == exp_data_q);
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // arm flushes the log on its edge, so neither push nor pop may race it
  assign push_req = armed & memwrite & ~arm;
  assign pop      = ~empty & log_ready & ~arm;
  assign push     = push_req & (~full | pop);

  always_comb begin
    state_nx = state;
    if (arm) begin
      state_nx = S_ARMED;
    end else if (armed) begin
      if (memwrite && adr_hit && data_hit)
        state_nx = S_PASS;
      else if (memwrite && adr_hit)
        state_nx = S_FAIL;
      else if (cyc_cnt == CYC_LAST)
        state_nx = S_TOUT;
    end
  end

  // Control, counters and verdict flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      store_count  <= '0;
      cyc_cnt      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      log_overflow <= 1'b0;
      exp_adr_q    <= '0;
      exp_data_q   <= '0;
    end else begin
      state   <= state_nx;
      pass    <= (state_nx == S_PASS);
      fail    <= (state_nx == S_FAIL) || (state_nx == S_TOUT);
      timeout <= (state_nx == S_TOUT);
      done    <= (state_nx == S_PASS) || (state_nx == S_FAIL) || (state_nx == S_TOUT);
      if (arm) begin
        exp_adr_q    <= exp_adr;
        exp_data_q   <= exp_data;
        store_count  <= '0;
        cyc_cnt      <= '0;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        log_overflow <= 1'b0;
      end else begin
        if (armed)
          cyc_cnt <= cyc_cnt + CNT_ONE;
        if (push_req)
          store_count <= sat_inc(store_count);
        if (push_req && full && !pop)
          log_overflow <= 1'b1;
        if (push)
          wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)
          rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Log storage carries no reset; the head is masked to zero while empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_adr[wr_ptr[AW-1:0]]  <= dataadr;
      mem_data[wr_ptr[AW-1:0]] <= writedata;
    end
  end

  assign log_valid = ~empty;
  assign log_adr   = empty ? 32'd0 : mem_adr[rd_ptr[AW-1:0]];
  assign log_data  = empty ? 32'd0 : mem_data[rd_ptr[AW-1:0]];

endmodule
